// File: rtl/asic_bridge_pkg.sv
// Shared types and default constants for the ASIC end of the SPI bridge link.
package asic_bridge_pkg;

  localparam int                       DEF_FRAME_W   = 16;
  localparam logic [DEF_FRAME_W-1:0]   DEF_IDLE_WORD = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } resp_state_t;

  typedef logic [DEF_FRAME_W-1:0] frame_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchroniser plus registered edge detect for one asynchronous SPI pin.
module spi_in_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              lvl_q, lvl_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Events compare the synchroniser output against the previous synchronised level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
    lvl_d  = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~lvl_q;
    fall_d = ~sync_q[STAGES-1] & lvl_q;
  end

  // Synchroniser, level and event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      lvl_q  <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/asic_spi_responder.sv
// SPI mode-0 responder emulating the ASIC end of the bridge link.
// Optional macro ASIC_SPI_RESP_ECHO_EN: fallback reply is the last good RX word instead of IDLE_WORD.
module asic_spi_responder
  import asic_bridge_pkg::*;
#(
  parameter int                 FRAME_W     = DEF_FRAME_W,
  parameter logic [FRAME_W-1:0] IDLE_WORD   = FRAME_W'(DEF_IDLE_WORD),
  parameter int                 SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               sclk_in,
  input  logic               mosi_in,
  input  logic               sel_in,
  output logic               miso_out,
  output logic               miso_oe,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

  resp_state_t        state_q, state_d;
  logic [FRAME_W-1:0] tx_shreg_q, tx_shreg_d;
  logic [FRAME_W-1:0] rx_shreg_q, rx_shreg_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               miso_q, miso_d;
  logic               oe_q, oe_d;
  logic               busy_q, busy_d;
  logic               tx_ready_q, tx_ready_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;

  logic [FRAME_W-1:0] fallback_s;
  logic [FRAME_W-1:0] rx_s;
  logic [CNT_W-1:0]   cnt_s;
  logic               accept_s, consume_s;
  logic               sel_lvl, sel_rise, sel_fall;
  logic               sclk_lvl, sclk_rise, sclk_fall;
  logic               mosi_lvl, mosi_rise, mosi_fall;
  logic               unused_sync_s;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sel_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(sel_in),
    .level(sel_lvl), .rise(sel_rise), .fall(sel_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(sclk_in),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(mosi_in),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync_s = ^{sel_lvl, sclk_lvl, mosi_rise, mosi_fall};

`ifdef ASIC_SPI_RESP_ECHO_EN
  assign fallback_s = rx_data_q;
`else
  assign fallback_s = IDLE_WORD;
`endif

  // Frame sequencing; within one CLK an sclk edge is applied before the sel_rise length check.
  always_comb begin
    state_d     = state_q;
    tx_shreg_d  = tx_shreg_q;
    rx_shreg_d  = rx_shreg_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    consume_s   = 1'b0;
    rx_s        = rx_shreg_q;
    cnt_s       = bit_cnt_q;

    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (sel_fall) begin
          consume_s  = ~tx_ready_q;
          tx_shreg_d = tx_ready_q ? fallback_s : hold_q;
          rx_shreg_d = '0;
          bit_cnt_d  = '0;
          miso_d     = tx_shreg_d[FRAME_W-1];
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_s  = {rx_shreg_q[FRAME_W-2:0], mosi_lvl};
          cnt_s = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + 1'b1;
        end else begin
          rx_s  = rx_shreg_q;
          cnt_s = bit_cnt_q;
        end
        rx_shreg_d = rx_s;
        bit_cnt_d  = cnt_s;

        // Past the last data bit the line simply holds its final value.
        if (sclk_fall && (cnt_s < CNT_FULL)) begin
          tx_shreg_d = {tx_shreg_q[FRAME_W-2:0], 1'b0};
          miso_d     = tx_shreg_q[FRAME_W-2];
        end else begin
          tx_shreg_d = tx_shreg_q;
          miso_d     = miso_q;
        end

        if (sel_rise) begin
          if (cnt_s == CNT_FULL) begin
            rx_data_d  = rx_s;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Accept and consume are exclusive: accept needs an empty holder, consume a full one.
    accept_s = tx_valid & tx_ready_q;
    if (consume_s) begin
      tx_ready_d = 1'b1;
      hold_d     = hold_q;
    end else if (accept_s) begin
      tx_ready_d = 1'b0;
      hold_d     = tx_data;
    end else begin
      tx_ready_d = tx_ready_q;
      hold_d     = hold_q;
    end

    oe_d   = (state_d == ST_SHIFT);
    busy_d = (state_d == ST_SHIFT);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      tx_shreg_q  <= '0;
      rx_shreg_q  <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shreg_q  <= tx_shreg_d;
      rx_shreg_q  <= rx_shreg_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_out  = miso_q;
  assign miso_oe   = oe_q;
  assign tx_ready  = tx_ready_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_asic_spi_responder.sv
// Randomised bench for asic_spi_responder: acts as SPI master and checks against a frame-level model.
module tb_asic_spi_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        sclk_in = 1'b0;
  logic        mosi_in = 1'b0;
  logic        sel_in = 1'b1;
  logic [15:0] tx_data = 16'h0000;
  logic        tx_valid = 1'b0;
  logic        miso_out, miso_oe, tx_ready, rx_valid, frame_err, busy;
  logic [15:0] rx_data;

`ifdef ASIC_SPI_RESP_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  asic_spi_responder dut (
    .CLK(CLK), .RST_N(RST_N), .sclk_in(sclk_in), .mosi_in(mosi_in), .sel_in(sel_in),
    .miso_out(miso_out), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_c;
  logic [15:0] cur_rx = 16'h0000;
  logic [15:0] model_rx = 16'h0000;
  logic [15:0] held_w = 16'h0000;
  bit          held = 1'b0;
  logic [15:0] got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Per-cycle comparison of pulses and rx_data against the expected frame outcomes.
  always @(negedge CLK) begin
    if (!RST_N) begin
      cur_rx = 16'h0000;
    end else begin
      chk("busy_vs_oe", busy, miso_oe);
      if (!miso_oe) chk("miso_idle", miso_out, 1'b0);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("pulse_unexpected", {rx_valid, frame_err}, 2'b00);
        end else begin
          e_c = exp_q.pop_front();
          chk("pulse_kind", {rx_valid, frame_err}, e_c.err ? 2'b01 : 2'b10);
          if (!e_c.err) cur_rx = e_c.data;
        end
      end
      chk("rx_data", rx_data, cur_rx);
    end
  end

  task automatic load_word(input logic [15:0] w);
    int n;
    n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("tx_ready_wait", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_data  = w;
    @(negedge CLK);
    tx_valid = 1'b0;
    chk("tx_ready_after_load", tx_ready, 1'b0);
    held   = 1'b1;
    held_w = w;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_miso_oe"}, miso_oe, 1'b0);
    chk({tag, "_miso_out"}, miso_out, 1'b0);
    chk({tag, "_tx_ready"}, tx_ready, 1'b1);
    chk({tag, "_rx_data"}, rx_data, 16'h0000);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // One select window with nrise sclk rises; always entered and left right after a negedge.
  task automatic run_frame(input logic [15:0] mosi, input int nrise, input bit tx_same,
                           input bit rst_mid, output logic [15:0] got_w);
    logic [15:0] expw, mask;
    int lat;
    expw  = held ? held_w : (ECHO ? model_rx : 16'hFFFF);
    held  = 1'b0;
    got_w = 16'h0000;
    mask  = 16'h0000;
    sel_in = 1'b0;
    if (tx_same) begin
      repeat (3) @(negedge CLK);
      tx_valid = 1'b1;
      tx_data  = 16'h0F0F;
      @(negedge CLK);
      tx_valid = 1'b0;
      held     = 1'b1;
      held_w   = 16'h0F0F;
      repeat (2) @(negedge CLK);
    end else begin
      repeat (6) @(negedge CLK);
    end
    chk("tx_ready_in_frame", tx_ready, {31'd0, !held});
    for (int i = 0; i < nrise; i++) begin
      mosi_in = (i < 16) ? mosi[15-i] : 1'b0;
      repeat (4) @(negedge CLK);
      sclk_in = 1'b1;
      if (i < 16) begin
        got_w[15-i] = miso_out;
        mask[15-i]  = 1'b1;
      end
      repeat (4) @(negedge CLK);
      sclk_in = 1'b0;
    end
    if (rst_mid) begin
      load_word(16'h5A5A);
      #2 RST_N = 1'b0;
      #1 check_reset_values("rst_mid");
      held     = 1'b0;
      model_rx = 16'h0000;
      exp_q.delete();
      sel_in  = 1'b1;
      mosi_in = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
    end else begin
      repeat (4) @(negedge CLK);
      chk("miso_bits", got_w & mask, expw & mask);
      sel_in = 1'b1;
      if (nrise == 16) begin
        exp_q.push_back({1'b0, mosi});
        model_rx = mosi;
      end else begin
        exp_q.push_back({1'b1, 16'h0000});
      end
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge CLK);
        if (rx_valid || frame_err) begin
          lat = k;
          break;
        end
      end
      chk("sel_rise_to_pulse", lat, 4);
      repeat (6) @(negedge CLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    load_word(16'hA5C3);
    run_frame(16'h1234, 16, 1'b0, 1'b0, got);
    chk("t2_miso", got, 16'hA5C3);
    chk("t2_rx", rx_data, 16'h1234);
    chk("t2_tx_ready", tx_ready, 1'b1);

    run_frame(16'h1234, 16, 1'b0, 1'b0, got);
    chk("t3_miso", got, ECHO ? 16'h1234 : 16'hFFFF);

    run_frame(16'hDEAD, 9, 1'b0, 1'b0, got);
    chk("t4_short_rx", rx_data, 16'h1234);
    run_frame(16'hBEEF, 17, 1'b0, 1'b0, got);
    chk("t4_long_rx", rx_data, 16'h1234);

    run_frame(16'h3C3C, 16, 1'b1, 1'b0, got);
    chk("t5_first_miso", got, ECHO ? 16'h1234 : 16'hFFFF);
    run_frame(16'h7E81, 16, 1'b0, 1'b0, got);
    chk("t5_second_miso", got, 16'h0F0F);

    run_frame(16'hCAFE, 5, 1'b0, 1'b1, got);
    run_frame(16'hBEEF, 16, 1'b0, 1'b0, got);
    chk("t6_rx", rx_data, 16'hBEEF);
    chk("t6_miso", got, ECHO ? 16'h0000 : 16'hFFFF);

    for (int r = 0; r < 12; r++) begin
      int n;
      if ($urandom_range(0, 1) == 1) load_word(16'($urandom));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 16;
      run_frame(16'($urandom), n, 1'b0, 1'b0, got);
    end

    repeat (10) @(negedge CLK);
    chk("pending_outcomes", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
